friscv_dispenser_n: RTL and testbench

FRISCV_DISPENSER_N -- requirements
Module: friscv_dispenser_n

---
 rtl/friscv_pkg.sv | 20 ++
 rtl/friscv_contador.sv | 26 ++
 rtl/friscv_dispenser_n.sv | 145 ++++++++++++++
 tb/tb_friscv_dispenser_n.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_pkg.sv
// Shared definitions for the juice dispenser: controller state codes and pour modes.
package friscv_pkg;

  localparam int unsigned ESTADO_W   = 4;
  localparam int unsigned MODE_TIMED = 0;
  localparam int unsigned MODE_LEVEL = 1;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO        = 4'd0,
    ESPERA        = 4'd1,
    MEDE_COPO     = 4'd2,
    AGUARDA_COPO  = 4'd3,
    ENCHE         = 4'd4,
    MEDE_NIVEL    = 4'd5,
    AGUARDA_NIVEL = 4'd6,
    FIM           = 4'd7,
    ERRO          = 4'd8
  } estado_t;

endpackage

// File: rtl/friscv_contador.sv
// Saturating up-counter with synchronous clear; fim flags the LIMIT-th counted cycle.
module friscv_contador #(
  parameter int unsigned LIMIT = 10,
  parameter int unsigned WIDTH = $clog2(LIMIT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      q <= '0;
    end else if (enable && (q != WIDTH'(LIMIT))) begin
      q <= q + WIDTH'(1);
    end
  end

  // High during the cycle in which the LIMIT-th enabled cycle is being spent
  assign fim = (q >= WIDTH'(LIMIT - 1));

endmodule

// File: rtl/friscv_dispenser_n.sv
// N-channel juice dispenser controller: cup check, timed or level-stop pour, fault latch.
module friscv_dispenser_n
  import friscv_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned DIST_W       = 9,
  parameter int unsigned MODE         = 0,
  parameter int unsigned CUP_MAX_CM   = 10,
  parameter int unsigned FILL_CM      = 4,
  parameter int unsigned POUR_CYCLES  = 100000,
  parameter int unsigned MEAS_PERIOD  = 5000,
  parameter int unsigned MEAS_TIMEOUT = 2000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              liga,
  input  logic [N_CH-1:0]   liga_suco,
  input  logic              medida_pronto,
  input  logic [DIST_W-1:0] medida,
  output logic              medir,
  output logic [N_CH-1:0]   ativa_bomba,
  output logic              pronto,
  output logic              erro,
  output logic [3:0]        db_estado
);

  localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  estado_t           state, state_next;
  logic [SEL_W-1:0]  sel, sel_next;
  logic [N_CH-1:0]   liga_suco_q, rise;
  logic              edge_found;
  logic [SEL_W-1:0]  edge_idx;
  logic              pump_on, pour_fim, per_fim, to_fim;
  logic              cup_ok, full;
  logic              medir_d, pronto_d, erro_d;
  logic [N_CH-1:0]   bomba_d;

  assign rise    = liga_suco & ~liga_suco_q;
  assign cup_ok  = (medida <= DIST_W'(CUP_MAX_CM));
  assign full    = (medida <= DIST_W'(FILL_CM));
  assign pump_on = (state == ENCHE) || (state == MEDE_NIVEL) || (state == AGUARDA_NIVEL);

  // Pour time spans the whole pour; period and timeout restart on each state entry
  friscv_contador #(.LIMIT(POUR_CYCLES)) u_pour (
    .clock(clock), .reset(reset), .clear(!pump_on), .enable(pump_on), .fim(pour_fim)
  );
  friscv_contador #(.LIMIT(MEAS_PERIOD)) u_period (
    .clock(clock), .reset(reset), .clear(state != ENCHE), .enable(state == ENCHE), .fim(per_fim)
  );
  friscv_contador #(.LIMIT(MEAS_TIMEOUT)) u_timeout (
    .clock(clock), .reset(reset),
    .clear((state != AGUARDA_COPO) && (state != AGUARDA_NIVEL)),
    .enable((state == AGUARDA_COPO) || (state == AGUARDA_NIVEL)),
    .fim(to_fim)
  );

  // Lowest-index rising edge wins
  always_comb begin
    edge_found = 1'b0;
    edge_idx   = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (rise[i]) begin
        edge_found = 1'b1;
        edge_idx   = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= OCIOSO;
      sel         <= '0;
      liga_suco_q <= '0;
    end else begin
      state       <= state_next;
      sel         <= sel_next;
      liga_suco_q <= liga_suco;
    end
  end

  always_comb begin
    state_next = state;
    sel_next   = sel;
    if (!liga) begin
      state_next = OCIOSO;
    end else begin
      case (state)
        OCIOSO:       state_next = ESPERA;
        ESPERA: begin
          if (edge_found) begin
            sel_next   = edge_idx;
            state_next = MEDE_COPO;
          end
        end
        MEDE_COPO:    state_next = AGUARDA_COPO;
        AGUARDA_COPO: begin
          if (medida_pronto)  state_next = cup_ok ? ENCHE : ERRO;
          else if (to_fim)    state_next = ERRO;
        end
        ENCHE: begin
          if (pour_fim)                          state_next = (MODE == MODE_LEVEL) ? ERRO : FIM;
          else if ((MODE == MODE_LEVEL) && per_fim) state_next = MEDE_NIVEL;
        end
        MEDE_NIVEL:   state_next = pour_fim ? ERRO : AGUARDA_NIVEL;
        AGUARDA_NIVEL: begin
          if (medida_pronto && full)      state_next = FIM;
          else if (pour_fim || to_fim)    state_next = ERRO;
          else if (medida_pronto)         state_next = ENCHE;
        end
        FIM:          state_next = ESPERA;
        ERRO:         state_next = ERRO;
        default:      state_next = OCIOSO;
      endcase
    end
  end

  // Outputs decoded from the next state so they register in step with it
  always_comb begin
    medir_d  = (state_next == MEDE_COPO) || (state_next == MEDE_NIVEL);
    pronto_d = (state_next == FIM);
    erro_d   = (state_next == ERRO);
    bomba_d  = '0;
    if ((state_next == ENCHE) || (state_next == MEDE_NIVEL) || (state_next == AGUARDA_NIVEL)) begin
      bomba_d = N_CH'(1) << sel_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      medir       <= 1'b0;
      pronto      <= 1'b0;
      erro        <= 1'b0;
      ativa_bomba <= '0;
      db_estado   <= '0;
    end else begin
      medir       <= medir_d;
      pronto      <= pronto_d;
      erro        <= erro_d;
      ativa_bomba <= bomba_d;
      db_estado   <= 4'(state_next);
    end
  end

endmodule

// File: tb/tb_friscv_dispenser_n.sv
// Scoreboard bench: a timed-pour and a level-stop instance, pours checked on completion.
module tb_friscv_dispenser_n;

  logic       clk = 1'b0;
  logic       reset0, reset1, liga0, liga1;
  logic [2:0] liga_suco;
  logic       medida_pronto;
  logic [8:0] medida;
  logic       medir0, medir1, pronto0, pronto1, erro0, erro1;
  logic [2:0] bomba0, bomba1;
  logic [3:0] db0, db1;

  always #5 clk = ~clk;

  friscv_dispenser_n #(.N_CH(3), .DIST_W(9), .MODE(0), .CUP_MAX_CM(10), .FILL_CM(4),
    .POUR_CYCLES(100), .MEAS_PERIOD(10), .MEAS_TIMEOUT(50)) dut0 (
    .clock(clk), .reset(reset0), .liga(liga0), .liga_suco(liga_suco),
    .medida_pronto(medida_pronto), .medida(medida), .medir(medir0),
    .ativa_bomba(bomba0), .pronto(pronto0), .erro(erro0), .db_estado(db0));

  friscv_dispenser_n #(.N_CH(3), .DIST_W(9), .MODE(1), .CUP_MAX_CM(10), .FILL_CM(4),
    .POUR_CYCLES(100), .MEAS_PERIOD(10), .MEAS_TIMEOUT(50)) dut1 (
    .clock(clk), .reset(reset1), .liga(liga1), .liga_suco(liga_suco),
    .medida_pronto(medida_pronto), .medida(medida), .medir(medir1),
    .ativa_bomba(bomba1), .pronto(pronto1), .erro(erro1), .db_estado(db1));

  logic       sel_inst;
  logic [2:0] m_bomba;
  logic [3:0] m_db;
  logic       m_medir, m_pronto, m_erro;
  assign m_bomba  = sel_inst ? bomba1  : bomba0;
  assign m_db     = sel_inst ? db1     : db0;
  assign m_medir  = sel_inst ? medir1  : medir0;
  assign m_pronto = sel_inst ? pronto1 : pronto0;
  assign m_erro   = sel_inst ? erro1   : erro0;

  typedef struct {
    logic [2:0] bomba;
    int         len;
    logic [1:0] outcome;  // {erro, pronto} on the first pump-off cycle
    bit         chk_len;
  } pour_t;

  pour_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    pronto_cnt = 0;
  int    run_len = 0;
  logic [2:0] cap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Pour monitor: closes a pump-on run and compares it with the oldest expectation
  always @(negedge clk) begin
    pour_t e;
    if (m_pronto) pronto_cnt++;
    if (m_bomba != 3'b000) begin
      if (run_len == 0) cap = m_bomba;
      run_len++;
    end else if (run_len != 0) begin
      if (sb.size() == 0) begin
        check("pour_unexpected", 32'(run_len), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pour_channel", 32'(cap), 32'(e.bomba));
        if (e.chk_len) check("pour_length", 32'(run_len), 32'(e.len));
        check("pour_outcome", 32'({m_erro, m_pronto}), 32'(e.outcome));
      end
      run_len = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pour(input logic [2:0] b, input int len, input logic [1:0] oc, input bit cl);
    pour_t e;
    e.bomba = b; e.len = len; e.outcome = oc; e.chk_len = cl;
    sb.push_back(e);
  endtask

  task automatic wait_medir(output bit seen, output int n_enche);
    seen = 1'b0;
    n_enche = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (m_db == 4'd4) n_enche++;
      if (m_medir) seen = 1'b1;
    end
    check("medir_seen", 32'(seen), 32'd1);
  endtask

  // Answer the next measurement request d cycles after it, optionally checking pour stint length
  task automatic serve_meas(input logic [8:0] v, input int d, input int exp_enche);
    bit seen;
    int n_enche;
    wait_medir(seen, n_enche);
    if (!seen) return;
    if (exp_enche >= 0) check("enche_stint", 32'(n_enche), 32'(exp_enche));
    tick(1);
    check("medir_one_cycle", 32'(m_medir), 32'd0);
    tick(d - 1);
    medida = v;
    medida_pronto = 1'b1;
    @(posedge clk);
    #1 medida_pronto = 1'b0;
  endtask

  task automatic wait_db(input string tag, input logic [3:0] v, input int limit);
    for (int i = 0; i < limit && m_db != v; i++) @(negedge clk);
    check(tag, 32'(m_db), 32'(v));
  endtask

  initial begin
    bit seen;
    int n_enche;
    sel_inst = 1'b0;
    reset0 = 1'b0; reset1 = 1'b0; liga0 = 1'b0; liga1 = 1'b0;
    liga_suco = 3'b000; medida_pronto = 1'b0; medida = 9'd0;
    tick(2);
    check("rst_db", 32'(db0), 32'd0);
    check("rst_outs", 32'({medir0, pronto0, erro0, bomba0}), 32'd0);
    reset0 = 1'b1; reset1 = 1'b1;
    liga0 = 1'b1;
    tick(1);
    check("ocioso_to_espera", 32'(db0), 32'd1);

    // Timed pour on channel 1
    pronto_cnt = 0;
    expect_pour(3'b010, 100, 2'b01, 1'b1);
    liga_suco = 3'b010;
    serve_meas(9'd8, 3, -1);
    wait_db("t0_back_espera", 4'd1, 300);
    check("t0_pronto_pulses", 32'(pronto_cnt), 32'd1);
    liga_suco = 3'b000;
    tick(2);

    // Simultaneous edges on 0 and 2
    expect_pour(3'b001, 100, 2'b01, 1'b1);
    liga_suco = 3'b101;
    serve_meas(9'd8, 1, -1);
    wait_db("prio_back_espera", 4'd1, 300);
    liga_suco = 3'b000;

    // Button held from before ESPERA never starts a pour
    liga0 = 1'b0;
    tick(1);
    check("liga_off_ocioso", 32'(db0), 32'd0);
    liga_suco = 3'b100;
    tick(2);
    liga0 = 1'b1;
    tick(20);
    check("held_no_pour", 32'(db0), 32'd1);
    liga_suco = 3'b000;
    tick(2);

    // Cup too far
    liga_suco = 3'b001;
    serve_meas(9'd15, 2, -1);
    tick(2);
    check("far_cup_erro", 32'(erro0), 32'd1);
    check("far_cup_db", 32'(db0), 32'd8);
    check("far_cup_pumps", 32'(bomba0), 32'd0);
    liga_suco = 3'b000;
    liga0 = 1'b0;
    tick(1);
    check("erro_clear_db", 32'(db0), 32'd0);
    check("erro_clear_flag", 32'(erro0), 32'd0);
    liga0 = 1'b1;
    tick(1);
    check("relig_espera", 32'(db0), 32'd1);

    // Measurement timeout boundary
    liga_suco = 3'b100;
    wait_medir(seen, n_enche);
    tick(50);
    check("timeout_last_wait", 32'(db0), 32'd3);
    tick(1);
    check("timeout_erro_db", 32'(db0), 32'd8);
    check("timeout_erro", 32'(erro0), 32'd1);
    liga0 = 1'b0;
    liga_suco = 3'b000;
    tick(1);
    liga0 = 1'b1;
    tick(1);

    // Reset in the middle of a pour
    expect_pour(3'b010, 0, 2'b00, 1'b0);
    liga_suco = 3'b010;
    serve_meas(9'd8, 1, -1);
    tick(30);
    check("midpour_pump_on", 32'(bomba0), 32'd2);
    reset0 = 1'b0;
    tick(1);
    check("midrst_db", 32'(db0), 32'd0);
    check("midrst_outs", 32'({medir0, pronto0, erro0, bomba0}), 32'd0);
    reset0 = 1'b1;
    liga0 = 1'b0;
    liga_suco = 3'b000;
    tick(2);

    // Level-stop instance
    sel_inst = 1'b1;
    reset1 = 1'b0;
    tick(2);
    reset1 = 1'b1;
    liga1 = 1'b1;
    tick(1);
    check("m1_espera", 32'(db1), 32'd1);
    expect_pour(3'b010, 52, 2'b01, 1'b1);
    liga_suco = 3'b010;
    serve_meas(9'd8, 2, -1);
    serve_meas(9'd9, 2, 10);
    serve_meas(9'd7, 2, 10);
    serve_meas(9'd5, 2, 10);
    serve_meas(9'd4, 2, 10);
    tick(1);
    check("m1_fim_pronto", 32'(pronto1), 32'd1);
    tick(1);
    check("m1_back_espera", 32'(db1), 32'd1);
    liga_suco = 3'b000;
    tick(2);

    // Never full: overflow safety after 100 pump cycles
    expect_pour(3'b001, 100, 2'b10, 1'b1);
    liga_suco = 3'b001;
    serve_meas(9'd8, 1, -1);
    for (int r = 0; r < 7; r++) serve_meas(9'd9, 2, 10);
    wait_db("m1_overflow_db", 4'd8, 200);
    tick(1);
    check("m1_overflow_erro", 32'(erro1), 32'd1);
    check("m1_overflow_pumps", 32'(bomba1), 32'd0);
    liga_suco = 3'b000;
    tick(2);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
